// File: rtl/parallel_to_sd_serializer_pkg.sv
// Shared signed-digit encodings, frame layout and FSM state type for the
// parallel-to-signed-digit serializer.
package parallel_to_sd_serializer_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_NEG  = 2'b11;

    localparam int SD_FRAME_W  = 3;
    localparam int SD_LAST_BIT = 2;
    localparam int SD_IDX_W    = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sd_state_e;

    // The MSD of a two's-complement fraction carries weight -1, all others +2^-k.
    function automatic logic [1:0] sd_encode(input logic is_msd, input logic bit_val);
        if (!bit_val) begin
            return SD_ZERO;
        end
        return is_msd ? SD_NEG : SD_POS;
    endfunction

endpackage

// File: rtl/parallel_to_sd_serializer_buffer.sv
// One-entry word holding buffer: write fills it, read empties it, data held while full.
// Latency 1 from write to full; the producer must not write while full.
module sd_word_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr_en) begin
            data_q <= wr_data;
            full_q <= 1'b1;
        end else if (rd_en) begin
            full_q <= 1'b0;
        end
    end

    assign rd_data = data_q;
    assign full    = full_q;

endmodule

// File: rtl/parallel_to_sd_serializer.sv
// Serializes two's-complement fraction words into signed digits, MSD first; first digit 1 cycle after accept.
// Valid/ready on both sides; one extra word is buffered so back-to-back words stream without a bubble.
module parallel_to_sd_serializer
    import parallel_to_sd_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [SD_FRAME_W-1:0] o_digit,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic [SD_IDX_W-1:0]   o_digit_idx
);

    localparam logic [SD_IDX_W-1:0] LAST_IDX = SD_IDX_W'(DATA_WIDTH - 1);

    sd_state_e             state_q;
    sd_state_e             state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [SD_IDX_W-1:0]   idx_q;

    logic                  buf_full;
    logic [DATA_WIDTH-1:0] buf_data;

    logic in_xfer;
    logic out_xfer;
    logic last_digit;
    logic last_xfer;

    logic load_in;
    logic load_buf;
    logic shift_en;
    logic drain;
    logic buf_wr;
    logic buf_rd;
    logic [1:0] sd;

    assign o_ready    = ~buf_full;
    assign o_valid    = (state_q == STREAM);
    assign in_xfer    = i_valid & o_ready;
    assign out_xfer   = o_valid & i_ready;
    assign last_digit = (idx_q == LAST_IDX);
    assign last_xfer  = out_xfer & last_digit;

    sd_word_buffer #(
        .WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .wr_en   (buf_wr),
        .wr_data (i_data),
        .rd_en   (buf_rd),
        .rd_data (buf_data),
        .full    (buf_full)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_in  = 1'b0;
        load_buf = 1'b0;
        shift_en = 1'b0;
        drain    = 1'b0;
        buf_wr   = 1'b0;
        buf_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    load_in = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    // A buffered word wins; o_ready is low then, so no input can collide.
                    if (buf_full) begin
                        load_buf = 1'b1;
                        buf_rd   = 1'b1;
                    end else if (in_xfer) begin
                        load_in = 1'b1;
                    end else begin
                        drain   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    shift_en = out_xfer;
                    buf_wr   = in_xfer;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (load_in) begin
            shift_q <= i_data;
            idx_q   <= '0;
        end else if (load_buf) begin
            shift_q <= buf_data;
            idx_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
            idx_q   <= idx_q + 1'b1;
        end else if (drain) begin
            shift_q <= '0;
            idx_q   <= '0;
        end
    end

    assign sd = sd_encode(idx_q == '0, shift_q[DATA_WIDTH-1]);

    always_comb begin
        o_digit = '0;
        if (o_valid) begin
            o_digit[SD_LAST_BIT] = last_digit;
            o_digit[1:0]         = sd;
        end
    end

    assign o_digit_idx = idx_q;
    assign o_busy      = o_valid | buf_full;

endmodule

// File: tb/tb_parallel_to_sd_serializer.sv
// Directed bench for the serializer at DATA_WIDTH = 8: single words, stalls,
// back-to-back streaming and mid-word reset, against hand-computed digit sequences.
module tb_parallel_to_sd_serializer;

    logic       clk;
    logic       rstn;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic [2:0] o_digit;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic [5:0] o_digit_idx;

    int total = 0;
    int bad   = 0;

    parallel_to_sd_serializer #(
        .DATA_WIDTH (8)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_digit     (o_digit),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_digit_idx (o_digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word, then consumes its 8 digits; stall[s] holds i_ready low in cycle s.
    task automatic run_word(input logic [7:0] w, input logic [23:0] e, input string tag,
                            input logic [15:0] stall);
        int k = 0;
        int s = 0;
        @(negedge clk);
        i_data  = w;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        while (k < 8 && s < 20) begin
            @(negedge clk);
            chk($sformatf("%s_vld%0d", tag, s), o_valid, 1'b1);
            chk($sformatf("%s_dig%0d", tag, s), o_digit, e[3*(7-k) +: 3]);
            chk($sformatf("%s_idx%0d", tag, s), o_digit_idx, k);
            chk($sformatf("%s_busy%0d", tag, s), o_busy, 1'b1);
            i_ready = ~stall[s];
            if (!stall[s]) k++;
            s++;
        end
        i_ready = 1'b1;
        chk({tag, "_count"}, k, 8);
        @(negedge clk);
        chk({tag, "_end_vld"}, o_valid, 1'b0);
        chk({tag, "_end_busy"}, o_busy, 1'b0);
        chk({tag, "_end_rdy"}, o_ready, 1'b1);
    endtask

    logic [47:0] e_ab;
    int          lasts;

    initial begin
        rstn    = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", o_valid, 1'b0);
        chk("rst_dig", o_digit, 3'b000);
        chk("rst_idx", o_digit_idx, 6'd0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_rdy", o_ready, 1'b1);
        rstn = 1'b1;

        run_word(8'h40, {3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100},
                 "w40", 16'h0000);
        run_word(8'hC1, {3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101},
                 "wC1", 16'h0000);
        run_word(8'h5A, {3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b100},
                 "stall5A", 16'h0006);

        // Back-to-back: A5 then 3C with no bubble between words.
        e_ab = {3'b011, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b101,
                3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100};
        lasts = 0;
        @(negedge clk);
        i_data  = 8'hA5;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_vld%0d", k), o_valid, 1'b1);
            chk($sformatf("b2b_dig%0d", k), o_digit, e_ab[3*(15-k) +: 3]);
            chk($sformatf("b2b_idx%0d", k), o_digit_idx, k % 8);
            chk($sformatf("b2b_rdy%0d", k), o_ready, (k >= 1 && k <= 7) ? 1'b0 : 1'b1);
            lasts += int'(o_digit[2]);
            if (k == 0) i_data = 8'h3C;
            if (k == 1) i_valid = 1'b0;
        end
        chk("b2b_lasts", lasts, 2);
        @(negedge clk);
        chk("b2b_end_vld", o_valid, 1'b0);
        chk("b2b_end_busy", o_busy, 1'b0);

        // Mid-word reset with a second word parked in the buffer.
        @(negedge clk);
        i_data  = 8'hFF;
        i_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) i_data = 8'h7F;
            if (k == 1) i_valid = 1'b0;
        end
        chk("mr_idx3", o_digit_idx, 6'd3);
        chk("mr_dig3", o_digit, 3'b001);
        chk("mr_rdy_full", o_ready, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_vld", o_valid, 1'b0);
        chk("mr_busy", o_busy, 1'b0);
        chk("mr_rdy", o_ready, 1'b1);
        chk("mr_dig", o_digit, 3'b000);
        chk("mr_idx", o_digit_idx, 6'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_post_vld", o_valid, 1'b0);
        chk("mr_post_busy", o_busy, 1'b0);

        run_word(8'h80, {3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100},
                 "w80", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parallel_to_sd_serializer.md
PARALLEL_TO_SD_SERIALIZER -- requirements
Module: parallel_to_sd_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width and digits emitted per word (legal range 2..64).
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rstn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port i_data, input, DATA_WIDTH, two's-complement fraction; MSB has weight -1, bit k has weight 2^-(DATA_WIDTH-1-k).
REQ-005 SHALL have port i_valid, input, 1, i_data is valid.
REQ-006 SHALL have port o_ready, output, 1, the block accepts i_data this cycle.
REQ-007 SHALL have port o_digit, output, 3, {last, sd[1:0]}; bit 2 marks the final digit of the word.
REQ-008 SHALL have port o_valid, output, 1, o_digit is valid.
REQ-009 SHALL have port i_ready, input, 1, consumer accepts o_digit.
REQ-010 SHALL have port o_busy, output, 1, at least one word is held (shifter or buffer).
REQ-011 SHALL have port o_digit_idx, output, 6, index of the digit currently on o_digit (0 = MSD).

Function
REQ-012 Signed-digit encoding SHALL be 2'b00 = 0, 2'b01 = +1, 2'b11 = -1; 2'b10 SHALL never be emitted.
REQ-013 Digit 0 SHALL be 2'b11 when MSB = 1 and 2'b00 otherwise; digits 1..DATA_WIDTH-1 SHALL be 2'b01/2'b00 from bits DATA_WIDTH-2 down to 0, MSD first.
REQ-014 o_digit[2] SHALL be 1 only on digit DATA_WIDTH-1 and 0 on every other digit.
REQ-015 Input transfer SHALL occur when i_valid & o_ready; output transfer SHALL occur when o_valid & i_ready.
REQ-016 Storage SHALL be a digit shifter plus a one-word holding buffer; o_ready SHALL equal ~buffer_full and SHALL depend only on registered state.
REQ-017 FSM SHALL have states IDLE (shifter empty, o_valid = 0) and STREAM (shifter loaded, o_valid = 1).
REQ-018 In IDLE, an input transfer SHALL load the shifter; the first digit SHALL appear with o_valid = 1 on the next cycle (latency 1).
REQ-019 In STREAM, an input transfer SHALL write the buffer, except in the same cycle as the last-digit output transfer with the buffer empty, when it SHALL load the shifter directly.
REQ-020 When the last digit transfers and the buffer is full, the buffer word SHALL move to the shifter in the same cycle, the FSM SHALL stay in STREAM, and the buffer SHALL become empty (zero-bubble back-to-back).
REQ-021 When the last digit transfers with the buffer empty and no input transfer, the FSM SHALL enter IDLE.
REQ-022 While o_valid & ~i_ready, o_digit and o_digit_idx SHALL stay stable.
REQ-023 o_digit_idx SHALL increment on each non-last output transfer and return to 0 when a new word loads.
REQ-024 o_busy SHALL equal (state == STREAM) | buffer_full.

Reset
REQ-025 While i_rstn = 0 at a clock edge: state = IDLE, buffer empty, o_valid = 0, o_digit = 3'b000, o_digit_idx = 0, o_busy = 0, o_ready = 1 on the following cycle.
REQ-026 Reset asserted mid-word SHALL discard the shifter and buffer contents, with no partial last digit emitted.

Structure
REQ-027 A shared package SHALL hold SD_ZERO, SD_POS, SD_NEG, SD_FRAME_W = 3 and SD_LAST_BIT = 2.
REQ-028 The holding buffer SHALL be one sub-module, sd_word_buffer (one entry, write/read/full); everything else SHALL be inline.

Verification (DATA_WIDTH = 8)
REQ-029 Input 8'h40, i_ready = 1 -> digits 00,01,00,00,00,00,00 then {1,00}; o_valid high for exactly 8 consecutive cycles.
REQ-030 Input 8'hC1 -> digits 11,01,00,00,00,00,00 then {1,01} (value -1 + 0.5 + 2^-7).
REQ-031 Two words presented back-to-back, i_ready = 1 -> 16 consecutive o_valid cycles, exactly two digits with bit 2 set, o_ready low only while the buffer is full.
REQ-032 i_ready toggled 1,0,0,1 during a word -> no digit lost or duplicated; o_digit held stable during the stalls.
REQ-033 i_rstn pulsed low at digit 3 -> next cycle o_valid = 0, o_busy = 0, o_ready = 1; a new word 8'h80 then yields 11 followed by seven 00 digits, the last with bit 2 set.
